tower_encode_sched: RTL and testbench

Frame sequencer for the Tower encoding pipeline (sparse parse -> indicator -> tree layer 1 -> tree layer 2).
- On Start, reads NUM_COUNTER 32-bit counters from a counter RAM (1-cycle read latency) and streams them into the pipeline with a valid strobe.
- Captures each per-counter result bit after a fixed pipeline latency and assembles them into a frame result vector.
- Signals completion with a Done pulse; supports abort.

---
 rtl/tower_encode_sched.sv | 127 ++++++++++++
 tb/tb_tower_encode_sched.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tower_encode_sched.sv
// Tower encode frame sequencer: reads NUM_COUNTER counters from RAM, streams them into the encode pipeline, packs the result bits.
// Done pulses NUM_COUNTER+PIPE_LAT+3 cycles after Start; no backpressure, the pipeline takes one counter per cycle.
module tower_encode_sched #(
    parameter int NUM_COUNTER = 10,
    parameter int ADDR_W      = 8,
    parameter int PIPE_LAT    = 3
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic                   Start,
    input  logic                   Abort,
    input  logic [ADDR_W-1:0]      Base_Addr,
    output logic                   Busy,
    output logic                   Done,
    output logic                   Mem_Rd_En,
    output logic [ADDR_W-1:0]      Mem_Addr,
    input  logic [31:0]            Mem_Rd_Data,
    output logic                   Enc_Clear,
    output logic [31:0]            Enc_Counter,
    output logic                   Enc_Valid,
    input  logic                   Enc_Result,
    output logic [NUM_COUNTER-1:0] Result_Vec
);
    localparam int CNT_W = (NUM_COUNTER > 1) ? $clog2(NUM_COUNTER) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_COUNTER - 1);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

    state_t                 state;
    logic [CNT_W-1:0]       idx;
    logic [CNT_W-1:0]       ridx;
    logic                   rd_d1;
    logic [PIPE_LAT-1:0]    vsr;
    logic [NUM_COUNTER-1:0] shadow;
    logic [NUM_COUNTER-1:0] cap_vec;
    logic                   accept;
    logic                   cap;

    assign accept    = (state == IDLE) && Start && !Abort;
    assign Enc_Clear = accept && !Reset;
    assign cap       = vsr[PIPE_LAT-1] && (state != IDLE);

    // shadow with the bit arriving this cycle merged in, so the final capture lands in Result_Vec directly
    always_comb begin
        cap_vec       = shadow;
        cap_vec[ridx] = Enc_Result;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state       <= IDLE;
            idx         <= '0;
            ridx        <= '0;
            rd_d1       <= 1'b0;
            vsr         <= '0;
            shadow      <= '0;
            Busy        <= 1'b0;
            Done        <= 1'b0;
            Mem_Rd_En   <= 1'b0;
            Mem_Addr    <= '0;
            Enc_Counter <= '0;
            Enc_Valid   <= 1'b0;
            Result_Vec  <= '0;
        end else begin
            Done      <= 1'b0;
            rd_d1     <= Mem_Rd_En;
            Enc_Valid <= rd_d1;
            if (rd_d1)
                Enc_Counter <= Mem_Rd_Data;
            vsr[0] <= Enc_Valid;
            for (int i = 1; i < PIPE_LAT; i++)
                vsr[i] <= vsr[i-1];
            if (cap) begin
                shadow <= cap_vec;
                ridx   <= ridx + CNT_W'(1);
            end

            case (state)
                IDLE: begin
                    if (accept) begin
                        state     <= FETCH;
                        Busy      <= 1'b1;
                        Mem_Rd_En <= 1'b1;
                        Mem_Addr  <= Base_Addr;
                        idx       <= '0;
                        ridx      <= '0;
                        shadow    <= '0;
                    end
                end
                FETCH: begin
                    if (idx == LAST) begin
                        Mem_Rd_En <= 1'b0;
                        state     <= DRAIN;
                    end else begin
                        idx      <= idx + CNT_W'(1);
                        Mem_Addr <= Mem_Addr + ADDR_W'(1);
                    end
                end
                DRAIN: begin
                    if (cap && ridx == LAST && !Abort) begin
                        state      <= DONE;
                        Done       <= 1'b1;
                        Result_Vec <= cap_vec;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    Busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase

            // abort drops any in-flight counters so a following frame sees no stale captures
            if (Abort && state != IDLE) begin
                state     <= IDLE;
                Busy      <= 1'b0;
                Done      <= 1'b0;
                Mem_Rd_En <= 1'b0;
                idx       <= '0;
                ridx      <= '0;
                rd_d1     <= 1'b0;
                Enc_Valid <= 1'b0;
                vsr       <= '0;
            end
        end
    end
endmodule

// File: tb/tb_tower_encode_sched.sv
// Directed bench for tower_encode_sched: default build (N=10, L=3) plus a N=1, L=1 build.
module tb_tower_encode_sched;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        start = 1'b0, abort = 1'b0;
    logic [7:0]  base_addr = '0;
    logic        busy, done, mem_rd_en, enc_clear, enc_valid, enc_result;
    logic [7:0]  mem_addr;
    logic [31:0] mem_rd_data = '0, enc_counter;
    logic [9:0]  result_vec;

    logic        start1 = 1'b0, abort1 = 1'b0;
    logic [7:0]  base_addr1 = '0;
    logic        busy1, done1, mem_rd_en1, enc_clear1, enc_valid1, enc_result1;
    logic [7:0]  mem_addr1;
    logic [31:0] mem_rd_data1 = '0, enc_counter1;
    logic [0:0]  result_vec1;

    logic [31:0] ram [256];
    logic [2:0]  res_sr = '0;
    logic        res_sr1 = 1'b0;

    int vectors = 0;
    int errors  = 0;

    tower_encode_sched #(.NUM_COUNTER(10), .ADDR_W(8), .PIPE_LAT(3)) dut (
        .Clk(clk), .Reset(rst), .Start(start), .Abort(abort), .Base_Addr(base_addr),
        .Busy(busy), .Done(done), .Mem_Rd_En(mem_rd_en), .Mem_Addr(mem_addr),
        .Mem_Rd_Data(mem_rd_data), .Enc_Clear(enc_clear), .Enc_Counter(enc_counter),
        .Enc_Valid(enc_valid), .Enc_Result(enc_result), .Result_Vec(result_vec)
    );

    tower_encode_sched #(.NUM_COUNTER(1), .ADDR_W(8), .PIPE_LAT(1)) dut1 (
        .Clk(clk), .Reset(rst), .Start(start1), .Abort(abort1), .Base_Addr(base_addr1),
        .Busy(busy1), .Done(done1), .Mem_Rd_En(mem_rd_en1), .Mem_Addr(mem_addr1),
        .Mem_Rd_Data(mem_rd_data1), .Enc_Clear(enc_clear1), .Enc_Counter(enc_counter1),
        .Enc_Valid(enc_valid1), .Enc_Result(enc_result1), .Result_Vec(result_vec1)
    );

    // RAM with one-cycle read latency and pipeline stubs returning Enc_Counter[0] after PIPE_LAT cycles
    always @(posedge clk) begin
        if (mem_rd_en)  mem_rd_data  <= ram[mem_addr];
        if (mem_rd_en1) mem_rd_data1 <= ram[mem_addr1];
        res_sr  <= {res_sr[1:0], enc_counter[0]};
        res_sr1 <= enc_counter1[0];
    end
    assign enc_result  = res_sr[2];
    assign enc_result1 = res_sr1;

    task automatic set_ram(input int mode);
        for (int a = 0; a < 256; a++)
            ram[a] = (mode == 0) ? 32'(a) : 32'(a >> 1);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        vectors++; if (busy !== 1'b0)       begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        vectors++; if (done !== 1'b0)       begin errors++; $display("FAIL reset_done got %b exp 0", done); end
        vectors++; if (mem_rd_en !== 1'b0)  begin errors++; $display("FAIL reset_rd_en got %b exp 0", mem_rd_en); end
        vectors++; if (mem_addr !== 8'h00)  begin errors++; $display("FAIL reset_addr got %h exp 00", mem_addr); end
        vectors++; if (enc_clear !== 1'b0)  begin errors++; $display("FAIL reset_clear got %b exp 0", enc_clear); end
        vectors++; if (enc_valid !== 1'b0)  begin errors++; $display("FAIL reset_valid got %b exp 0", enc_valid); end
        vectors++; if (enc_counter !== 32'h0) begin errors++; $display("FAIL reset_counter got %h exp 0", enc_counter); end
        vectors++; if (result_vec !== 10'h0) begin errors++; $display("FAIL reset_result got %b exp 0", result_vec); end
        vectors++; if (busy1 !== 1'b0)      begin errors++; $display("FAIL reset_busy1 got %b exp 0", busy1); end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        logic exp_rd, exp_v;
        set_ram(0);
        next_cycle();
        base_addr = 8'h10; start = 1'b1;
        @(negedge clk);
        vectors++; if (enc_clear !== 1'b1) begin errors++; $display("FAIL basic_clear got %b exp 1", enc_clear); end
        next_cycle();
        start = 1'b0;
        for (int k = 1; k <= 17; k++) begin
            @(negedge clk);
            exp_rd = (k >= 1 && k <= 10);
            exp_v  = (k >= 3 && k <= 12);
            vectors++; if (mem_rd_en !== exp_rd) begin errors++; $display("FAIL basic_rd_en c%0d got %b exp %b", k, mem_rd_en, exp_rd); end
            if (exp_rd) begin
                vectors++; if (mem_addr !== 8'(8'h10 + k - 1)) begin errors++; $display("FAIL basic_addr c%0d got %h exp %h", k, mem_addr, 8'(8'h10 + k - 1)); end
            end
            vectors++; if (enc_valid !== exp_v) begin errors++; $display("FAIL basic_valid c%0d got %b exp %b", k, enc_valid, exp_v); end
            if (exp_v) begin
                vectors++; if (enc_counter !== 32'(16 + k - 3)) begin errors++; $display("FAIL basic_counter c%0d got %h exp %h", k, enc_counter, 32'(16 + k - 3)); end
            end
            vectors++; if (done !== (k == 16)) begin errors++; $display("FAIL basic_done c%0d got %b exp %b", k, done, (k == 16)); end
            vectors++; if (busy !== (k <= 16)) begin errors++; $display("FAIL basic_busy c%0d got %b exp %b", k, busy, (k <= 16)); end
            if (k == 16) begin
                vectors++; if (result_vec !== 10'b1010101010) begin errors++; $display("FAIL basic_result got %b exp 1010101010", result_vec); end
            end
            next_cycle();
        end
    endtask

    task automatic test_wrap();
        logic [7:0] exp_addr [10] = '{8'hFC, 8'hFD, 8'hFE, 8'hFF, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        set_ram(1);
        base_addr = 8'hFC; start = 1'b1;
        next_cycle();
        start = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            if (k <= 10) begin
                vectors++; if (mem_addr !== exp_addr[k-1]) begin errors++; $display("FAIL wrap_addr c%0d got %h exp %h", k, mem_addr, exp_addr[k-1]); end
            end
            if (k == 16) begin
                vectors++; if (done !== 1'b1) begin errors++; $display("FAIL wrap_done got %b exp 1", done); end
                vectors++; if (result_vec !== 10'b0011001100) begin errors++; $display("FAIL wrap_result got %b exp 0011001100", result_vec); end
            end
            next_cycle();
        end
    endtask

    task automatic test_start_busy();
        int ndone;
        set_ram(0);
        ndone = 0;
        base_addr = 8'h10; start = 1'b1;
        next_cycle();
        for (int k = 1; k <= 17; k++) begin
            start = (k == 5 || k == 16 || k == 17);
            @(negedge clk);
            if (done === 1'b1) ndone++;
            if (k == 5 || k == 16) begin
                vectors++; if (enc_clear !== 1'b0) begin errors++; $display("FAIL busy_start_clear c%0d got %b exp 0", k, enc_clear); end
            end
            if (k == 17) begin
                vectors++; if (enc_clear !== 1'b1) begin errors++; $display("FAIL busy_restart_clear got %b exp 1", enc_clear); end
                vectors++; if (ndone !== 1) begin errors++; $display("FAIL busy_done_count got %0d exp 1", ndone); end
            end
            next_cycle();
        end
        start = 1'b0;
        ndone = 0;
        for (int j = 1; j <= 16; j++) begin
            @(negedge clk);
            if (j < 16 && done === 1'b1) ndone++;
            if (j == 16) begin
                vectors++; if (ndone !== 0) begin errors++; $display("FAIL busy_early_done got %0d exp 0", ndone); end
                vectors++; if (done !== 1'b1) begin errors++; $display("FAIL busy_second_done got %b exp 1", done); end
                vectors++; if (result_vec !== 10'b1010101010) begin errors++; $display("FAIL busy_result got %b exp 1010101010", result_vec); end
            end
            next_cycle();
        end
    endtask

    task automatic test_abort();
        int ndone;
        set_ram(1);
        base_addr = 8'h10; start = 1'b1; abort = 1'b1;
        @(negedge clk);
        vectors++; if (enc_clear !== 1'b0) begin errors++; $display("FAIL abort_start_clear got %b exp 0", enc_clear); end
        next_cycle();
        start = 1'b0; abort = 1'b0;
        @(negedge clk);
        vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_start_busy got %b exp 0", busy); end
        next_cycle();
        start = 1'b1;
        next_cycle();
        ndone = 0;
        for (int k = 1; k <= 25; k++) begin
            abort = (k == 8);
            start = (k == 9);
            @(negedge clk);
            if (k < 25 && done === 1'b1) ndone++;
            if (k == 9) begin
                vectors++; if (busy !== 1'b0)      begin errors++; $display("FAIL abort_busy got %b exp 0", busy); end
                vectors++; if (enc_valid !== 1'b0) begin errors++; $display("FAIL abort_valid got %b exp 0", enc_valid); end
                vectors++; if (mem_rd_en !== 1'b0) begin errors++; $display("FAIL abort_rd_en got %b exp 0", mem_rd_en); end
                vectors++; if (enc_clear !== 1'b1) begin errors++; $display("FAIL abort_restart_clear got %b exp 1", enc_clear); end
            end
            if (k == 24) begin
                vectors++; if (result_vec !== 10'b1010101010) begin errors++; $display("FAIL abort_kept_result got %b exp 1010101010", result_vec); end
                vectors++; if (ndone !== 0) begin errors++; $display("FAIL abort_spurious_done got %0d exp 0", ndone); end
            end
            if (k == 25) begin
                vectors++; if (done !== 1'b1) begin errors++; $display("FAIL abort_next_done got %b exp 1", done); end
                vectors++; if (result_vec !== 10'b0011001100) begin errors++; $display("FAIL abort_next_result got %b exp 0011001100", result_vec); end
            end
            next_cycle();
        end
        abort = 1'b0; start = 1'b0;
    endtask

    task automatic test_reset_mid();
        set_ram(1);
        base_addr = 8'h10; start = 1'b1;
        next_cycle();
        start = 1'b0;
        repeat (5) next_cycle();
        rst = 1'b1;
        #1;
        vectors++; if (busy !== 1'b0)       begin errors++; $display("FAIL rstmid_busy got %b exp 0", busy); end
        vectors++; if (enc_valid !== 1'b0)  begin errors++; $display("FAIL rstmid_valid got %b exp 0", enc_valid); end
        vectors++; if (mem_rd_en !== 1'b0)  begin errors++; $display("FAIL rstmid_rd_en got %b exp 0", mem_rd_en); end
        vectors++; if (result_vec !== 10'h0) begin errors++; $display("FAIL rstmid_result got %b exp 0", result_vec); end
        @(negedge clk);
        rst = 1'b0;
        next_cycle();
        start = 1'b1;
        next_cycle();
        start = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            vectors++; if (done !== (k == 16)) begin errors++; $display("FAIL rstmid_done c%0d got %b exp %b", k, done, (k == 16)); end
            if (k == 16) begin
                vectors++; if (result_vec !== 10'b0011001100) begin errors++; $display("FAIL rstmid_result_after got %b exp 0011001100", result_vec); end
            end
            next_cycle();
        end
    endtask

    task automatic test_single();
        logic [7:0] bases [2] = '{8'h23, 8'h22};
        logic [0:0] exp_res [2] = '{1'b1, 1'b0};
        set_ram(0);
        for (int t = 0; t < 2; t++) begin
            base_addr1 = bases[t]; start1 = 1'b1;
            @(negedge clk);
            vectors++; if (enc_clear1 !== 1'b1) begin errors++; $display("FAIL single_clear t%0d got %b exp 1", t, enc_clear1); end
            next_cycle();
            start1 = 1'b0;
            for (int k = 1; k <= 6; k++) begin
                @(negedge clk);
                vectors++; if (mem_rd_en1 !== (k == 1)) begin errors++; $display("FAIL single_rd_en c%0d got %b exp %b", k, mem_rd_en1, (k == 1)); end
                if (k == 1) begin
                    vectors++; if (mem_addr1 !== bases[t]) begin errors++; $display("FAIL single_addr got %h exp %h", mem_addr1, bases[t]); end
                end
                vectors++; if (enc_valid1 !== (k == 3)) begin errors++; $display("FAIL single_valid c%0d got %b exp %b", k, enc_valid1, (k == 3)); end
                vectors++; if (done1 !== (k == 5)) begin errors++; $display("FAIL single_done c%0d got %b exp %b", k, done1, (k == 5)); end
                vectors++; if (busy1 !== (k <= 5)) begin errors++; $display("FAIL single_busy c%0d got %b exp %b", k, busy1, (k <= 5)); end
                if (k == 5) begin
                    vectors++; if (result_vec1 !== exp_res[t]) begin errors++; $display("FAIL single_result t%0d got %b exp %b", t, result_vec1, exp_res[t]); end
                end
                next_cycle();
            end
        end
    endtask

    initial begin
        set_ram(0);
        test_reset();
        test_basic();
        test_wrap();
        test_start_busy();
        test_abort();
        test_reset_mid();
        test_single();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
